// File: rtl/ysyx_23060077_ifu_fetch_pkg.sv
// Shared fetch-unit definitions: FSM state encodings, datapath width and reset PC.
package ysyx_23060077_ifu_fetch_pkg;

  localparam int YSYX_23060077_DATA_WIDTH = 32;
  localparam logic [31:0] YSYX_23060077_RESET_PC = 32'h3000_0000;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_OUT  = 2'd2
  } ifu_state_e;

  function automatic logic is_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/ysyx_23060077_ifu_perf.sv
// Fetch-unit performance counters: IDU handshakes, WAIT cycles and discarded fetches.
module ysyx_23060077_ifu_perf (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_inc,
  input  logic        wait_inc,
  input  logic        flush_inc,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_wait_cnt,
  output logic [31:0] perf_flush_cnt
);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_wait_cnt  <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (fetch_inc) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (wait_inc)  perf_wait_cnt  <= perf_wait_cnt + 32'd1;
      if (flush_inc) perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/ysyx_23060077_ifu_fetch.sv
// PC register and single-outstanding instruction-fetch sequencer feeding the IDU.
// Optional perf counters are built when YSYX_23060077_IFU_PERF_EN is defined.
module ysyx_23060077_ifu_fetch
  import ysyx_23060077_ifu_fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = YSYX_23060077_DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = YSYX_23060077_RESET_PC
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic                  ifu_valid,
  input  logic                  ifu_ready,
  output logic [DATA_WIDTH-1:0] ifu_pc,
  output logic [DATA_WIDTH-1:0] ifu_inst,
  output logic                  ifu_fault
`ifdef YSYX_23060077_IFU_PERF_EN
  ,
  output logic [31:0]           perf_fetch_cnt,
  output logic [31:0]           perf_wait_cnt,
  output logic [31:0]           perf_flush_cnt
`endif
);

  ifu_state_e            state;
  logic [DATA_WIDTH-1:0] pc;
  logic [DATA_WIDTH-1:0] req_addr;
  logic                  drop;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] pc_inc;
  logic [DATA_WIDTH-1:0] refetch_addr;

  assign pc_inc       = pc + DATA_WIDTH'(4);
  // A response discarded together with a same-cycle redirect refetches the new target.
  assign refetch_addr = redirect_valid ? redirect_pc : pc;
  assign mem_req_addr = req_addr;
  // A wrong-path instruction is never handed over, even in the redirect cycle itself.
  assign ifu_valid    = out_valid & ~redirect_valid;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_REQ;
      pc            <= RESET_PC;
      req_addr      <= RESET_PC;
      drop          <= 1'b0;
      mem_req_valid <= 1'b0;
      out_valid     <= 1'b0;
      ifu_pc        <= '0;
      ifu_inst      <= '0;
      ifu_fault     <= 1'b0;
    end else begin
      if (redirect_valid) pc <= redirect_pc;
      case (state)
        ST_REQ: begin
          if (!mem_req_valid) begin
            // Idle REQ: startup, or a misaligned target that must not reach the bus.
            if (redirect_valid) begin
              req_addr      <= redirect_pc;
              mem_req_valid <= is_aligned(redirect_pc[1:0]);
            end else if (!is_aligned(req_addr[1:0])) begin
              state     <= ST_OUT;
              out_valid <= 1'b1;
              ifu_pc    <= req_addr;
              ifu_inst  <= '0;
              ifu_fault <= 1'b1;
            end else begin
              mem_req_valid <= 1'b1;
            end
          end else begin
            if (redirect_valid) drop <= 1'b1;
            if (mem_req_ready) begin
              mem_req_valid <= 1'b0;
              state         <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (mem_rsp_valid) begin
            if (drop || redirect_valid) begin
              drop          <= 1'b0;
              state         <= ST_REQ;
              req_addr      <= refetch_addr;
              mem_req_valid <= is_aligned(refetch_addr[1:0]);
            end else begin
              state     <= ST_OUT;
              out_valid <= 1'b1;
              ifu_pc    <= pc;
              ifu_inst  <= mem_rsp_err ? '0 : mem_rsp_data;
              ifu_fault <= mem_rsp_err;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        ST_OUT: begin
          if (redirect_valid) begin
            state         <= ST_REQ;
            out_valid     <= 1'b0;
            req_addr      <= redirect_pc;
            mem_req_valid <= is_aligned(redirect_pc[1:0]);
          end else if (ifu_ready) begin
            state         <= ST_REQ;
            out_valid     <= 1'b0;
            pc            <= pc_inc;
            req_addr      <= pc_inc;
            mem_req_valid <= is_aligned(pc_inc[1:0]);
          end
        end
        default: state <= ST_REQ;
      endcase
    end
  end

`ifdef YSYX_23060077_IFU_PERF_EN
  logic fetch_inc;
  logic wait_inc;
  logic flush_inc;

  assign fetch_inc = ifu_valid & ifu_ready;
  assign wait_inc  = (state == ST_WAIT);
  assign flush_inc = ((state == ST_WAIT) & mem_rsp_valid & (drop | redirect_valid))
                   | ((state == ST_OUT) & out_valid & redirect_valid);

  ysyx_23060077_ifu_perf u_perf (
    .clock          (clock),
    .reset          (reset),
    .fetch_inc      (fetch_inc),
    .wait_inc       (wait_inc),
    .flush_inc      (flush_inc),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_wait_cnt  (perf_wait_cnt),
    .perf_flush_cnt (perf_flush_cnt)
  );
`endif

endmodule
